// File: rtl/tdm_demux1x4_if.sv
// Bundle for the tdm_demux1x4 receive link: serial input side plus reassembled parallel words.
// master drives the serial stream; slave is the demultiplexer.
interface tdm_demux1x4_if #(
  parameter int unsigned DATA_W = 8
);
  logic              din;
  logic              din_valid;
  logic              frame_sync;
  logic [1:0]        sel;
  logic              locked;
  logic [DATA_W-1:0] out0;
  logic [DATA_W-1:0] out1;
  logic [DATA_W-1:0] out2;
  logic [DATA_W-1:0] out3;
  logic              out_valid;
  logic              sync_err;

  modport master (
    output din,
    output din_valid,
    output frame_sync,
    input  sel,
    input  locked,
    input  out0,
    input  out1,
    input  out2,
    input  out3,
    input  out_valid,
    input  sync_err
  );

  modport slave (
    input  din,
    input  din_valid,
    input  frame_sync,
    output sel,
    output locked,
    output out0,
    output out1,
    output out2,
    output out3,
    output out_valid,
    output sync_err
  );
endinterface

// File: rtl/tdm_demux1x4.sv
// Receive end of a 4-channel round-robin TDM serial link: frame lock on a sync marker,
// per-channel MSB-first shift registers, and a parallel word group with a valid pulse.
module tdm_demux1x4 #(
  parameter int unsigned DATA_W = 8
) (
  input logic           clk,
  input logic           rst_n,
  tdm_demux1x4_if.slave bus
);

  localparam int unsigned CntW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CntW-1:0] LastFrame = CntW'(DATA_W - 1);

  typedef enum logic [0:0] {
    StHunt,
    StLocked
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        slot_q, slot_d;
  logic [CntW-1:0]   frame_q, frame_d;
  logic [DATA_W-1:0] sh_q  [4];
  logic [DATA_W-1:0] sh_d  [4];
  logic [DATA_W-1:0] out_q [4];
  logic [DATA_W-1:0] out_d [4];
  logic              out_valid_q, out_valid_d;
  logic              sync_err_q, sync_err_d;
  logic              start_group;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StHunt;
      slot_q      <= 2'd0;
      frame_q     <= '0;
      out_valid_q <= 1'b0;
      sync_err_q  <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        sh_q[i]  <= '0;
        out_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      frame_q     <= frame_d;
      out_valid_q <= out_valid_d;
      sync_err_q  <= sync_err_d;
      for (int i = 0; i < 4; i++) begin
        sh_q[i]  <= sh_d[i];
        out_q[i] <= out_d[i];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    frame_d     = frame_q;
    out_valid_d = 1'b0;
    sync_err_d  = 1'b0;
    start_group = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sh_d[i]  = sh_q[i];
      out_d[i] = out_q[i];
    end

    if (bus.din_valid) begin
      unique case (state_q)
        StHunt: begin
          if (bus.frame_sync) begin
            state_d     = StLocked;
            start_group = 1'b1;
          end
        end
        StLocked: begin
          // A marker anywhere but slot 0 / frame 0 realigns, even on a completing bit.
          if (bus.frame_sync && ((slot_q != 2'd0) || (frame_q != '0))) begin
            sync_err_d  = 1'b1;
            start_group = 1'b1;
          end else begin
            sh_d[slot_q] = {sh_q[slot_q][DATA_W-2:0], bus.din};
            slot_d       = slot_q + 2'd1;
            if (slot_q == 2'd3) begin
              if (frame_q == LastFrame) begin
                frame_d     = '0;
                out_valid_d = 1'b1;
                for (int i = 0; i < 4; i++) begin
                  out_d[i] = sh_d[i];
                end
              end else begin
                frame_d = frame_q + CntW'(1);
              end
            end
          end
        end
        default: state_d = StHunt;
      endcase
    end

    // New group: drop partial words and take this bit as ch0 MSB-side first bit.
    if (start_group) begin
      for (int i = 1; i < 4; i++) begin
        sh_d[i] = '0;
      end
      sh_d[0] = {{(DATA_W-1){1'b0}}, bus.din};
      slot_d  = 2'd1;
      frame_d = '0;
    end
  end

  assign bus.sel       = (state_q == StLocked) ? slot_q : 2'd0;
  assign bus.locked    = (state_q == StLocked);
  assign bus.out0      = out_q[0];
  assign bus.out1      = out_q[1];
  assign bus.out2      = out_q[2];
  assign bus.out3      = out_q[3];
  assign bus.out_valid = out_valid_q;
  assign bus.sync_err  = sync_err_q;

endmodule

// File: tb/tb_tdm_demux1x4.sv
// Bench for tdm_demux1x4: directed word groups plus random traffic, checked every cycle
// against a bit-index model of the word group.
module tb_tdm_demux1x4;

  localparam int unsigned DW = 8;
  localparam int GroupBits = 4 * DW;

  logic clk;
  logic rst_n;

  tdm_demux1x4_if #(.DATA_W(DW)) bus ();

  tdm_demux1x4 #(.DATA_W(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int ov_cnt   = 0;
  int se_cnt   = 0;
  int prev_ov  = 0;
  int last_ov  = 0;

  // Reference: position of the next bit within the word group, and the words being built.
  bit          m_locked;
  int          m_idx;
  logic [DW-1:0] m_words [4];
  logic [DW-1:0] m_out   [4];
  bit          m_ov;
  bit          m_se;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic place_bit(input logic d);
    int ch;
    int pos;
    ch  = m_idx % 4;
    pos = DW - 1 - (m_idx / 4);
    m_words[ch][pos] = d;
  endtask

  task automatic model_step(input logic rst, input logic v, input logic d, input logic fs);
    m_ov = 1'b0;
    m_se = 1'b0;
    if (!rst) begin
      m_locked = 1'b0;
      m_idx    = 0;
      for (int i = 0; i < 4; i++) begin
        m_words[i] = '0;
        m_out[i]   = '0;
      end
    end else if (v) begin
      if (!m_locked) begin
        if (fs) begin
          m_locked = 1'b1;
          m_idx    = 0;
          place_bit(d);
          m_idx    = 1;
        end
      end else if (fs && m_idx != 0) begin
        m_se  = 1'b1;
        m_idx = 0;
        place_bit(d);
        m_idx = 1;
      end else begin
        place_bit(d);
        if (m_idx == GroupBits - 1) begin
          for (int i = 0; i < 4; i++) m_out[i] = m_words[i];
          m_ov  = 1'b1;
          m_idx = 0;
        end else begin
          m_idx++;
        end
      end
    end
  endtask

  task automatic compare_all();
    check("sel", 32'(bus.sel), m_locked ? 32'(m_idx % 4) : 32'd0);
    check("locked", 32'(bus.locked), 32'(m_locked));
    check("out0", 32'(bus.out0), 32'(m_out[0]));
    check("out1", 32'(bus.out1), 32'(m_out[1]));
    check("out2", 32'(bus.out2), 32'(m_out[2]));
    check("out3", 32'(bus.out3), 32'(m_out[3]));
    check("out_valid", 32'(bus.out_valid), 32'(m_ov));
    check("sync_err", 32'(bus.sync_err), 32'(m_se));
    if (bus.out_valid) begin
      ov_cnt++;
      prev_ov = last_ov;
      last_ov = cyc;
    end
    if (bus.sync_err) se_cnt++;
  endtask

  task automatic drive_bit(input logic v, input logic d, input logic fs);
    bus.din_valid  = v;
    bus.din        = d;
    bus.frame_sync = fs;
    @(posedge clk);
    cyc++;
    model_step(rst_n, v, d, fs);
    @(negedge clk);
    compare_all();
  endtask

  task automatic send_bits(input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                           input logic [DW-1:0] w2, input logic [DW-1:0] w3,
                           input int first, input int count, input logic fs_first,
                           input bit gaps);
    logic [DW-1:0] w [4];
    int ch;
    w[0] = w0;
    w[1] = w1;
    w[2] = w2;
    w[3] = w3;
    for (int i = first; i < first + count; i++) begin
      ch = i % 4;
      drive_bit(1'b1, w[ch][DW-1-(i/4)], fs_first && (i == first));
      if (gaps && ((i - first) % 5 == 4)) begin
        repeat (3) drive_bit(1'b0, 1'($urandom), 1'($urandom));
      end
    end
  endtask

  initial begin
    bus.din        = 1'b0;
    bus.din_valid  = 1'b0;
    bus.frame_sync = 1'b0;
    rst_n          = 1'b0;
    m_locked       = 1'b0;
    m_idx          = 0;
    m_ov           = 1'b0;
    m_se           = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_words[i] = '0;
      m_out[i]   = '0;
    end
    @(negedge clk);

    // Reset, then unsynced traffic must stay in hunt.
    repeat (2) drive_bit(1'($urandom), 1'($urandom), 1'b0);
    rst_n = 1'b1;
    repeat (24) drive_bit(1'($urandom), 1'($urandom), 1'b0);
    check("hunt_no_valid", 32'(ov_cnt), 32'd0);
    check("hunt_locked", 32'(bus.locked), 32'd0);

    // Single contiguous group.
    ov_cnt = 0;
    send_bits(8'hA5, 8'h3C, 8'hFF, 8'h01, 0, GroupBits, 1'b1, 1'b0);
    check("g1_pulses", 32'(ov_cnt), 32'd1);
    check("g1_out0", 32'(bus.out0), 32'h A5);
    check("g1_out1", 32'(bus.out1), 32'h3C);
    check("g1_out2", 32'(bus.out2), 32'hFF);
    check("g1_out3", 32'(bus.out3), 32'h01);

    // Same group with gaps; confirming sync at the boundary is legal.
    ov_cnt = 0;
    se_cnt = 0;
    send_bits(8'hA5, 8'h3C, 8'hFF, 8'h01, 0, GroupBits, 1'b1, 1'b1);
    check("gap_pulses", 32'(ov_cnt), 32'd1);
    check("gap_sync_err", 32'(se_cnt), 32'd0);
    check("gap_out0", 32'(bus.out0), 32'hA5);
    check("gap_out3", 32'(bus.out3), 32'h01);

    // Back-to-back groups, sync only on the first.
    ov_cnt = 0;
    send_bits(8'h11, 8'h22, 8'h33, 8'h44, 0, GroupBits, 1'b1, 1'b0);
    check("b2b_first_out1", 32'(bus.out1), 32'h22);
    send_bits(8'hDE, 8'hAD, 8'hBE, 8'hEF, 0, GroupBits, 1'b0, 1'b0);
    check("b2b_pulses", 32'(ov_cnt), 32'd2);
    check("b2b_spacing", 32'(last_ov - prev_ov), 32'(GroupBits));
    check("b2b_out0", 32'(bus.out0), 32'hDE);
    check("b2b_out3", 32'(bus.out3), 32'hEF);

    // Realignment at bit 13: old outputs kept, new group counts from the marker.
    ov_cnt = 0;
    se_cnt = 0;
    send_bits(8'h01, 8'h02, 8'h03, 8'h04, 0, 13, 1'b0, 1'b0);
    send_bits(8'hC3, 8'h96, 8'h0F, 8'hF0, 0, 1, 1'b1, 1'b0);
    check("realign_err", 32'(se_cnt), 32'd1);
    check("realign_keep0", 32'(bus.out0), 32'hDE);
    send_bits(8'hC3, 8'h96, 8'h0F, 8'hF0, 1, GroupBits - 1, 1'b0, 1'b0);
    check("realign_pulses", 32'(ov_cnt), 32'd1);
    check("realign_out1", 32'(bus.out1), 32'h96);
    check("realign_out3", 32'(bus.out3), 32'hF0);

    // Reset mid-group, then a fresh group.
    send_bits(8'h77, 8'h77, 8'h77, 8'h77, 0, 20, 1'b1, 1'b0);
    rst_n = 1'b0;
    repeat (2) drive_bit(1'b1, 1'($urandom), 1'b0);
    rst_n = 1'b1;
    check("rst_out0", 32'(bus.out0), 32'd0);
    check("rst_locked", 32'(bus.locked), 32'd0);
    se_cnt = 0;
    send_bits(8'h5A, 8'h5A, 8'h5A, 8'h5A, 0, GroupBits, 1'b1, 1'b0);
    check("post_rst_err", 32'(se_cnt), 32'd0);
    check("post_rst_out0", 32'(bus.out0), 32'h5A);
    check("post_rst_out2", 32'(bus.out2), 32'h5A);

    // Random traffic with occasional syncs and resets.
    for (int n = 0; n < 3000; n++) begin
      rst_n = ($urandom_range(0, 799) != 0);
      drive_bit($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 47) == 0);
    end
    rst_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
